// File: rtl/ui_pkg.sv
// Shared constants and point type for the UI capture / segment queue datapath.
// Also provides the helper used to size the shared value bus.
package ui_pkg;

    localparam int UI_XW = 9;
    localparam int UI_YW = 8;
    localparam int UI_CW = 3;

    localparam logic MODE_POLY = 1'b0;
    localparam logic MODE_PAIR = 1'b1;

    typedef struct packed {
        logic [UI_XW-1:0] x;
        logic [UI_YW-1:0] y;
        logic [UI_CW-1:0] c;
    } point_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ui_point_fifo.sv
// Point queue: single push, pop of 0/1/2 entries per cycle, with combinational
// peek of the head and the entry behind it.
module ui_point_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CNTW = AW + 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_flush,
    input  logic            i_push,
    input  logic [W-1:0]    i_data,
    input  logic [1:0]      i_pop,
    output logic [W-1:0]    o_head,
    output logic [W-1:0]    o_head1,
    output logic [CNTW-1:0] o_count,
    output logic            o_full,
    output logic            o_empty
);

    logic [W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [AW-1:0]   rd_ptr1;
    logic            push_ok;

    assign o_full  = (count_q == CNTW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign rd_ptr1 = rd_ptr_q + AW'(1);
    assign o_head  = mem_q[rd_ptr_q];
    assign o_head1 = mem_q[rd_ptr1];

    // A push into a full queue is only accepted when a pop frees space this cycle.
    assign push_ok = i_push & (!o_full | (i_pop != 2'd0)) & !i_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + AW'(i_pop);
            wr_ptr_d = wr_ptr_q + AW'(push_ok);
            count_d  = count_q + CNTW'(push_ok) - CNTW'(i_pop);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; its contents are meaningless until written.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: rtl/ui_point_queue.sv
// Stages X/Y/colour from the switch bus, queues committed points and hands
// line segments to the drawer in polyline or pair mode.
module ui_point_queue
    import ui_pkg::*;
#(
    parameter int XW    = UI_XW,
    parameter int YW    = UI_YW,
    parameter int CW    = UI_CW,
    parameter int DEPTH = 8,
    localparam int VW   = max3(XW, YW, CW),
    localparam int CNTW = $clog2(DEPTH) + 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [VW-1:0]   i_val,
    input  logic            i_setx,
    input  logic            i_sety,
    input  logic            i_setcol,
    input  logic            i_commit,
    input  logic            i_mode,
    input  logic            i_flush,
    input  logic            i_clr_drop,
    input  logic            i_ready,
    output logic            o_valid,
    output logic [XW-1:0]   o_x0,
    output logic [YW-1:0]   o_y0,
    output logic [XW-1:0]   o_x1,
    output logic [YW-1:0]   o_y1,
    output logic [CW-1:0]   o_color,
    output logic [XW-1:0]   o_xin,
    output logic [YW-1:0]   o_yin,
    output logic [CW-1:0]   o_cin,
    output logic [CNTW-1:0] o_count,
    output logic            o_full,
    output logic            o_empty,
    output logic            o_drop
);

    localparam int PW = XW + YW + CW;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] c_q, c_d;
    logic [XW-1:0] px_q, px_d;
    logic [YW-1:0] py_q, py_d;
    logic          drop_q, drop_d;

    logic [PW-1:0] head, head1;
    logic [XW-1:0] h0_x, h1_x;
    logic [YW-1:0] h0_y, h1_y;
    logic [CW-1:0] h0_c, h1_c;
    logic          handshake;
    logic          drop_event;
    logic [1:0]    pop_n;

    ui_point_fifo #(
        .W     (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (i_flush),
        .i_push  (i_commit),
        .i_data  ({x_q, y_q, c_q}),
        .i_pop   (pop_n),
        .o_head  (head),
        .o_head1 (head1),
        .o_count (o_count),
        .o_full  (o_full),
        .o_empty (o_empty)
    );

    assign h0_x = head[PW-1 -: XW];
    assign h0_y = head[CW +: YW];
    assign h0_c = head[CW-1:0];
    assign h1_x = head1[PW-1 -: XW];
    assign h1_y = head1[CW +: YW];
    assign h1_c = head1[CW-1:0];

    assign o_valid    = (i_mode == MODE_PAIR) ? (o_count >= CNTW'(2)) : !o_empty;
    assign handshake  = o_valid & i_ready & !i_flush;
    assign pop_n      = !handshake ? 2'd0 : ((i_mode == MODE_PAIR) ? 2'd2 : 2'd1);
    // Commit into a full queue with no pop to make room is lost and flagged.
    assign drop_event = i_commit & o_full & !handshake & !i_flush;

    always_comb begin
        if (i_mode == MODE_PAIR) begin
            o_x0    = h0_x;
            o_y0    = h0_y;
            o_x1    = h1_x;
            o_y1    = h1_y;
            o_color = h1_c;
        end else begin
            o_x0    = px_q;
            o_y0    = py_q;
            o_x1    = h0_x;
            o_y1    = h0_y;
            o_color = h0_c;
        end
    end

    always_comb begin
        x_d    = i_setx   ? i_val[XW-1:0] : x_q;
        y_d    = i_sety   ? i_val[YW-1:0] : y_q;
        c_d    = i_setcol ? i_val[CW-1:0] : c_q;
        px_d   = px_q;
        py_d   = py_q;
        drop_d = (drop_q & !i_clr_drop) | drop_event;
        if (handshake) begin
            px_d = (i_mode == MODE_PAIR) ? h1_x : h0_x;
            py_d = (i_mode == MODE_PAIR) ? h1_y : h0_y;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            x_q    <= '0;
            y_q    <= '0;
            c_q    <= '0;
            px_q   <= '0;
            py_q   <= '0;
            drop_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            c_q    <= c_d;
            px_q   <= px_d;
            py_q   <= py_d;
            drop_q <= drop_d;
        end
    end

    assign o_xin  = x_q;
    assign o_yin  = y_q;
    assign o_cin  = c_q;
    assign o_drop = drop_q;

endmodule
